// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubble, timed MDU stall and branch squash,
// plus a saturating count of cycles in which the PC was held.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | normal issue; branch > MDU start > load-use resolved here
//   BUSY  | MDU op still occupying EX; front end held, cnt timing it out
module hazard_unit #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_idr,
  input  logic [4:0]       rs2_idr,
  input  logic             uses_rs1_idr,
  input  logic             uses_rs2_idr,
  input  logic [4:0]       rd_exr,
  input  logic             RegWrite_exr,
  input  logic             MemRead_exr,
  input  logic             mdu_start_exr,
  input  logic             branch_taken_exr,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_write,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = (MDU_LATENCY >= 3) ? 4'(MDU_LATENCY - 3) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mdu_rel_q, mdu_rel_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             rs1_hit, rs2_hit;

  assign rs1_hit = uses_rs1_idr && (rs1_idr == rd_exr);
  assign rs2_hit = uses_rs2_idr && (rs2_idr == rd_exr);
  assign lu      = MemRead_exr && RegWrite_exr && (rd_exr != 5'd0) && (rs1_hit || rs2_hit);

  // mdu_rel_q marks the cycle after the last stall cycle: the op is still in EX
  // with mdu_start_exr held, and must not be mistaken for a new MDU op.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdu_rel_d   = 1'b0;
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (branch_taken_exr) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (mdu_start_exr && !mdu_rel_q && (MDU_LATENCY >= 2)) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_flush = 1'b1;
            if (MDU_LATENCY >= 3) begin
              cnt_d   = CNT_INIT;
              state_d = BUSY;
            end else begin
              mdu_rel_d = 1'b1;
            end
          end else if (lu) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
          end
        end
        BUSY: begin
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          IDEX_write  = 1'b0;
          EXMEM_flush = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d   = RUN;
            mdu_rel_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_write && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      mdu_rel_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_rel_q   <= mdu_rel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: five builds share one stimulus bus;
// each vector queues its expected outputs for the build under test.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_idr, rs2_idr, rd_exr;
  logic       uses_rs1_idr, uses_rs2_idr, RegWrite_exr, MemRead_exr;
  logic       mdu_start_exr, branch_taken_exr;

  always #5 clk = ~clk;

  // {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush}
  localparam logic [5:0] O_RST = 6'b110100;
  localparam logic [5:0] O_LU  = 6'b000110;
  localparam logic [5:0] O_MDU = 6'b000001;
  localparam logic [5:0] O_BR  = 6'b111110;

  localparam int D_L4 = 0, D_L2 = 1, D_L1 = 2, D_L6 = 3, D_SAT = 4;

  logic [5:0]  o_a [5];
  logic [31:0] c_a [5];
  logic [2:0]  sat_cnt;

  typedef struct {
    string      nm;
    int         d;
    logic [5:0] eo;
    int         ec;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  hazard_unit #(.MDU_LATENCY(4), .CNT_W(32)) u_l4 (
    .clk(clk), .rst(rst), .rs1_idr(rs1_idr), .rs2_idr(rs2_idr),
    .uses_rs1_idr(uses_rs1_idr), .uses_rs2_idr(uses_rs2_idr), .rd_exr(rd_exr),
    .RegWrite_exr(RegWrite_exr), .MemRead_exr(MemRead_exr),
    .mdu_start_exr(mdu_start_exr), .branch_taken_exr(branch_taken_exr),
    .PC_write(o_a[0][5]), .IFID_write(o_a[0][4]), .IFID_flush(o_a[0][3]),
    .IDEX_write(o_a[0][2]), .IDEX_flush(o_a[0][1]), .EXMEM_flush(o_a[0][0]),
    .stall_cnt(c_a[0]));

  hazard_unit #(.MDU_LATENCY(2), .CNT_W(32)) u_l2 (
    .clk(clk), .rst(rst), .rs1_idr(rs1_idr), .rs2_idr(rs2_idr),
    .uses_rs1_idr(uses_rs1_idr), .uses_rs2_idr(uses_rs2_idr), .rd_exr(rd_exr),
    .RegWrite_exr(RegWrite_exr), .MemRead_exr(MemRead_exr),
    .mdu_start_exr(mdu_start_exr), .branch_taken_exr(branch_taken_exr),
    .PC_write(o_a[1][5]), .IFID_write(o_a[1][4]), .IFID_flush(o_a[1][3]),
    .IDEX_write(o_a[1][2]), .IDEX_flush(o_a[1][1]), .EXMEM_flush(o_a[1][0]),
    .stall_cnt(c_a[1]));

  hazard_unit #(.MDU_LATENCY(1), .CNT_W(32)) u_l1 (
    .clk(clk), .rst(rst), .rs1_idr(rs1_idr), .rs2_idr(rs2_idr),
    .uses_rs1_idr(uses_rs1_idr), .uses_rs2_idr(uses_rs2_idr), .rd_exr(rd_exr),
    .RegWrite_exr(RegWrite_exr), .MemRead_exr(MemRead_exr),
    .mdu_start_exr(mdu_start_exr), .branch_taken_exr(branch_taken_exr),
    .PC_write(o_a[2][5]), .IFID_write(o_a[2][4]), .IFID_flush(o_a[2][3]),
    .IDEX_write(o_a[2][2]), .IDEX_flush(o_a[2][1]), .EXMEM_flush(o_a[2][0]),
    .stall_cnt(c_a[2]));

  hazard_unit #(.MDU_LATENCY(6), .CNT_W(32)) u_l6 (
    .clk(clk), .rst(rst), .rs1_idr(rs1_idr), .rs2_idr(rs2_idr),
    .uses_rs1_idr(uses_rs1_idr), .uses_rs2_idr(uses_rs2_idr), .rd_exr(rd_exr),
    .RegWrite_exr(RegWrite_exr), .MemRead_exr(MemRead_exr),
    .mdu_start_exr(mdu_start_exr), .branch_taken_exr(branch_taken_exr),
    .PC_write(o_a[3][5]), .IFID_write(o_a[3][4]), .IFID_flush(o_a[3][3]),
    .IDEX_write(o_a[3][2]), .IDEX_flush(o_a[3][1]), .EXMEM_flush(o_a[3][0]),
    .stall_cnt(c_a[3]));

  hazard_unit #(.MDU_LATENCY(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .rs1_idr(rs1_idr), .rs2_idr(rs2_idr),
    .uses_rs1_idr(uses_rs1_idr), .uses_rs2_idr(uses_rs2_idr), .rd_exr(rd_exr),
    .RegWrite_exr(RegWrite_exr), .MemRead_exr(MemRead_exr),
    .mdu_start_exr(mdu_start_exr), .branch_taken_exr(branch_taken_exr),
    .PC_write(o_a[4][5]), .IFID_write(o_a[4][4]), .IFID_flush(o_a[4][3]),
    .IDEX_write(o_a[4][2]), .IDEX_flush(o_a[4][1]), .EXMEM_flush(o_a[4][0]),
    .stall_cnt(sat_cnt));

  assign c_a[4] = {29'd0, sat_cnt};

  // Drive one cycle of inputs just after the edge; expectation is checked at negedge.
  task automatic cyc(input string nm, input int d, input logic r,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic e1, input logic e2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic md, input logic br,
                     input logic [5:0] eo, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1_idr = a1; rs2_idr = a2; uses_rs1_idr = e1; uses_rs2_idr = e2;
    rd_exr = rd; RegWrite_exr = rw; MemRead_exr = mr;
    mdu_start_exr = md; branch_taken_exr = br;
    e.nm = nm; e.d = d; e.eo = eo; e.ec = ec;
    sb.push_back(e);
  endtask

  task automatic idle(input string nm, input int d, input logic [5:0] eo, input int ec);
    cyc(nm, d, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, eo, ec);
  endtask

  task automatic mdu(input string nm, input int d, input logic [5:0] eo, input int ec);
    cyc(nm, d, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, eo, ec);
  endtask

  task automatic ldu(input string nm, input int d, input logic [5:0] eo, input int ec);
    cyc(nm, d, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, eo, ec);
  endtask

  task automatic do_reset(input int d);
    cyc("rst", d, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, -1);
    cyc("rst", d, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (o_a[e.d] !== e.eo) begin
          errors++;
          $display("FAIL %s dut%0d outputs: got %b expected %b", e.nm, e.d, o_a[e.d], e.eo);
        end
        if (e.ec >= 0) begin
          checks++;
          if (c_a[e.d] !== 32'(e.ec)) begin
            errors++;
            $display("FAIL %s dut%0d stall_cnt: got %0d expected %0d", e.nm, e.d, c_a[e.d], e.ec);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; rs1_idr = '0; rs2_idr = '0; rd_exr = '0;
    uses_rs1_idr = 0; uses_rs2_idr = 0; RegWrite_exr = 0; MemRead_exr = 0;
    mdu_start_exr = 0; branch_taken_exr = 0;

    // reset dominates a live load-use hit
    do_reset(D_L4);
    cyc("rst_lu", D_L4, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_RST, 0);

    ldu("lu_rs2", D_L4, O_LU, 0);
    idle("lu_rel", D_L4, O_RST, 1);
    cyc("g_rd0", D_L4, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_RST, 1);
    cyc("g_nouse", D_L4, 1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_RST, 1);
    cyc("g_nomr", D_L4, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_RST, 1);
    cyc("g_norw", D_L4, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, O_RST, 1);
    cyc("lu_rs1", D_L4, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_LU, 1);
    idle("lu1_rel", D_L4, O_RST, 2);

    // MDU latency 4: three stall cycles, released on the fourth
    do_reset(D_L4);
    mdu("m4_c1", D_L4, O_MDU, 0);
    mdu("m4_c2", D_L4, O_MDU, 1);
    mdu("m4_c3", D_L4, O_MDU, 2);
    mdu("m4_c4", D_L4, O_RST, 3);
    idle("m4_idle", D_L4, O_RST, 3);
    ldu("m4_run", D_L4, O_LU, 3);
    idle("m4_end", D_L4, O_RST, 4);

    do_reset(D_L2);
    mdu("m2_c1", D_L2, O_MDU, 0);
    mdu("m2_c2", D_L2, O_RST, 1);
    ldu("m2_run", D_L2, O_LU, 1);
    idle("m2_end", D_L2, O_RST, 2);

    do_reset(D_L1);
    mdu("m1_c1", D_L1, O_RST, 0);
    idle("m1_end", D_L1, O_RST, 0);

    // branch beats load-use and MDU; FSM must not leave RUN
    do_reset(D_L4);
    cyc("br_lu", D_L4, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, O_BR, 0);
    idle("br_lu_rel", D_L4, O_RST, 0);
    cyc("br_mdu", D_L4, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, O_BR, 0);
    idle("br_mdu_run", D_L4, O_RST, 0);
    idle("br_mdu_run2", D_L4, O_RST, 0);

    // reset on the second stall cycle of a latency-6 op
    do_reset(D_L6);
    mdu("m6_c1", D_L6, O_MDU, 0);
    cyc("m6_rst", D_L6, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, O_RST, 1);
    idle("m6_post", D_L6, O_RST, 0);
    idle("m6_post2", D_L6, O_RST, 0);
    ldu("m6_run", D_L6, O_LU, 0);
    idle("m6_end", D_L6, O_RST, 1);

    // 3-bit counter: ten stalls, holds at 7
    do_reset(D_SAT);
    mdu("s_a1", D_SAT, O_MDU, 0);
    mdu("s_a2", D_SAT, O_MDU, 1);
    mdu("s_a3", D_SAT, O_MDU, 2);
    mdu("s_a4", D_SAT, O_RST, 3);
    mdu("s_b1", D_SAT, O_MDU, 3);
    mdu("s_b2", D_SAT, O_MDU, 4);
    mdu("s_b3", D_SAT, O_MDU, 5);
    mdu("s_b4", D_SAT, O_RST, 6);
    mdu("s_c1", D_SAT, O_MDU, 6);
    mdu("s_c2", D_SAT, O_MDU, 7);
    mdu("s_c3", D_SAT, O_MDU, 7);
    mdu("s_c4", D_SAT, O_RST, 7);
    ldu("s_lu", D_SAT, O_LU, 7);
    idle("s_end", D_SAT, O_RST, 7);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
